// File: rtl/pwm_ramp_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : pwm_ramp_sequencer
// Brief   : Ramps two PWM pulse widths toward targets in fixed steps per tick.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module pwm_ramp_sequencer #(
  parameter int WIDTH    = 8,
  parameter int PERIOD_W = 32
) (
  input  logic                sys_clk,
  input  logic                sys_reset,
  input  logic                start,
  input  logic                abort,
  input  logic                pause,
  input  logic [WIDTH-1:0]    target1,
  input  logic [WIDTH-1:0]    target2,
  input  logic [WIDTH-1:0]    step_size,
  input  logic [PERIOD_W-1:0] step_period,
  output logic [WIDTH-1:0]    width1,
  output logic [WIDTH-1:0]    width2,
  output logic                busy,
  output logic                done
);

  localparam logic [WIDTH-1:0]    c_step_one = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PERIOD_W-1:0] c_per_one  = {{(PERIOD_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2
  } state_t;

  state_t              r_state, w_state_nx;
  logic [PERIOD_W-1:0] r_cnt, w_cnt_nx;
  logic [PERIOD_W-1:0] r_per, w_per_nx;
  logic [WIDTH-1:0]    r_tgt1, w_tgt1_nx;
  logic [WIDTH-1:0]    r_tgt2, w_tgt2_nx;
  logic [WIDTH-1:0]    r_step, w_step_nx;
  logic [WIDTH-1:0]    w_w1_nx, w_w2_nx;
  logic                w_busy_nx, w_done_nx;
  logic [WIDTH-1:0]    w_step_in, w_stp1, w_stp2;
  logic [PERIOD_W-1:0] w_per_in;
  logic                w_hit_new;

  // Move w one step toward tgt; the extra sum bit prevents wrap past full scale.
  function automatic logic [WIDTH-1:0] f_approach(input logic [WIDTH-1:0] w,
                                                  input logic [WIDTH-1:0] tgt,
                                                  input logic [WIDTH-1:0] stp);
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res;
    sum = {1'b0, w} + {1'b0, stp};
    res = w;
    if (w < tgt)
      res = (sum > {1'b0, tgt}) ? tgt : sum[WIDTH-1:0];
    else if (w > tgt)
      res = ((w - tgt) <= stp) ? tgt : (w - stp);
    return res;
  endfunction

  assign w_step_in = (step_size == '0) ? c_step_one : step_size;
  assign w_per_in  = (step_period == '0) ? c_per_one : step_period;
  assign w_hit_new = (width1 == target1) && (width2 == target2);
  assign w_stp1    = f_approach(width1, r_tgt1, r_step);
  assign w_stp2    = f_approach(width2, r_tgt2, r_step);

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_per_nx   = r_per;
    w_tgt1_nx  = r_tgt1;
    w_tgt2_nx  = r_tgt2;
    w_step_nx  = r_step;
    w_w1_nx    = width1;
    w_w2_nx    = width2;
    w_done_nx  = 1'b0;

    if (abort) begin
      if (r_state != S_IDLE) begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = '0;
      end
    end else if (start) begin
      w_tgt1_nx = target1;
      w_tgt2_nx = target2;
      w_step_nx = w_step_in;
      w_per_nx  = w_per_in;
      if (w_hit_new) begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = '0;
        w_done_nx  = 1'b1;
      end else begin
        w_state_nx = S_RUN;
        w_cnt_nx   = w_per_in - c_per_one;
      end
    end else if (r_state != S_IDLE) begin
      // An unpaused PAUSED cycle counts like a RUN cycle, so a pause of N cycles delays by N.
      if (pause) begin
        w_state_nx = S_PAUSED;
      end else if (r_cnt != '0) begin
        w_state_nx = S_RUN;
        w_cnt_nx   = r_cnt - c_per_one;
      end else begin
        w_w1_nx = w_stp1;
        w_w2_nx = w_stp2;
        if ((w_stp1 == r_tgt1) && (w_stp2 == r_tgt2)) begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = '0;
          w_done_nx  = 1'b1;
        end else begin
          w_state_nx = S_RUN;
          w_cnt_nx   = r_per - c_per_one;
        end
      end
    end

    w_busy_nx = (w_state_nx != S_IDLE);
  end

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_per   <= '0;
      r_tgt1  <= '0;
      r_tgt2  <= '0;
      r_step  <= '0;
      width1  <= '0;
      width2  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_per   <= w_per_nx;
      r_tgt1  <= w_tgt1_nx;
      r_tgt2  <= w_tgt2_nx;
      r_step  <= w_step_nx;
      width1  <= w_w1_nx;
      width2  <= w_w2_nx;
      busy    <= w_busy_nx;
      done    <= w_done_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_ramp_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : tb_pwm_ramp_sequencer
// Brief   : Self-checking bench with an edge-timeline model of the ramp sequencer.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_pwm_ramp_sequencer;

  logic        sys_clk = 1'b0;
  logic        sys_reset = 1'b1;
  logic        start = 1'b0, abort = 1'b0, pause = 1'b0;
  logic [7:0]  target1 = '0, target2 = '0, step_size = '0;
  logic [31:0] step_period = '0;
  logic [7:0]  width1, width2;
  logic        busy, done;

  int checks = 0;
  int errors = 0;

  // Model: absolute edge numbers instead of a down-counter.
  int m_w1, m_w2, m_t1, m_t2, m_st, m_per, m_next, ecount;
  bit m_active, m_done;

  pwm_ramp_sequencer #(.WIDTH(8), .PERIOD_W(32)) dut (
    .sys_clk(sys_clk), .sys_reset(sys_reset), .start(start), .abort(abort),
    .pause(pause), .target1(target1), .target2(target2), .step_size(step_size),
    .step_period(step_period), .width1(width1), .width2(width2), .busy(busy), .done(done)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic int approach(input int w, input int t, input int s);
    if (w < t) return (w + s > t) ? t : w + s;
    if (w > t) return (w - s < t) ? t : w - s;
    return w;
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at edge %0d", nm, got, exp, ecount);
    end
  endtask

  task automatic check_model();
    chk("width1", int'(width1), m_w1);
    chk("width2", int'(width2), m_w2);
    chk("busy", int'(busy), int'(m_active));
    chk("done", int'(done), int'(m_done));
  endtask

  task automatic model_reset();
    m_w1 = 0; m_w2 = 0; m_t1 = 0; m_t2 = 0; m_st = 0; m_per = 0;
    m_active = 0; m_done = 0; m_next = 0;
  endtask

  task automatic model_edge(input bit st, input bit ab, input bit pa,
                            input int t1, input int t2, input int sz, input int pr);
    int e;
    e = ecount + 1;
    m_done = 0;
    if (ab) begin
      m_active = 0;
    end else if (st) begin
      m_t1 = t1; m_t2 = t2;
      m_st = (sz == 0) ? 1 : sz;
      m_per = (pr == 0) ? 1 : pr;
      if (m_w1 == m_t1 && m_w2 == m_t2) begin
        m_active = 0; m_done = 1;
      end else begin
        m_active = 1; m_next = e + m_per;
      end
    end else if (m_active) begin
      if (pa) m_next++;
      else if (e == m_next) begin
        m_w1 = approach(m_w1, m_t1, m_st);
        m_w2 = approach(m_w2, m_t2, m_st);
        if (m_w1 == m_t1 && m_w2 == m_t2) begin
          m_active = 0; m_done = 1;
        end else m_next = e + m_per;
      end
    end
    ecount = e;
  endtask

  task automatic tick(input bit st, input bit ab, input bit pa,
                      input int t1, input int t2, input int sz, input int pr);
    start = st; abort = ab; pause = pa;
    target1 = 8'(t1); target2 = 8'(t2); step_size = 8'(sz); step_period = 32'(pr);
    model_edge(st, ab, pa, t1, t2, sz, pr);
    @(posedge sys_clk);
    #1;
    check_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    sys_reset = 1'b1;
    start = 0; abort = 0; pause = 0;
    #2;
    chk("rst_width1", int'(width1), 0);
    chk("rst_width2", int'(width2), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    model_reset();
    @(posedge sys_clk);
    ecount++;
    #1;
    sys_reset = 1'b0;
  endtask

  initial begin
    ecount = 0;
    model_reset();
    #1;
    do_reset();

    // 1 + 3: up-ramp with a 5-cycle pause after the first step
    tick(1, 0, 0, 10, 4, 3, 2);
    idle(2);
    chk("t3_w1_first", int'(width1), 3);
    chk("t3_w2_first", int'(width2), 3);
    for (int i = 0; i < 5; i++) tick(0, 0, 1, 0, 0, 0, 0);
    chk("t3_hold_w1", int'(width1), 3);
    chk("t3_busy_paused", int'(busy), 1);
    idle(2);
    chk("t3_w1_delayed", int'(width1), 6);
    idle(4);
    chk("t3_final_w1", int'(width1), 10);
    chk("t3_final_w2", int'(width2), 4);
    chk("t3_done", int'(done), 1);
    chk("t3_busy_end", int'(busy), 0);
    idle(2);

    // 1: unpaused up-ramp timing
    do_reset();
    tick(1, 0, 0, 10, 4, 3, 2);
    for (int i = 1; i <= 9; i++) begin
      tick(0, 0, 0, 0, 0, 0, 0);
      if (i == 2) chk("t1_w1_k2", int'(width1), 3);
      if (i == 4) chk("t1_w1_k4", int'(width1), 6);
      if (i == 6) chk("t1_w1_k6", int'(width1), 9);
      if (i == 8) begin
        chk("t1_w1_k8", int'(width1), 10);
        chk("t1_w2_k8", int'(width2), 4);
        chk("t1_done_k8", int'(done), 1);
      end
      if (i == 9) chk("t1_done_k9", int'(done), 0);
    end

    // 2: saturation without wrap
    do_reset();
    tick(1, 0, 0, 250, 250, 250, 1);
    idle(2);
    tick(1, 0, 0, 0, 255, 100, 1);
    idle(1);
    chk("t2_w1_s1", int'(width1), 150);
    chk("t2_w2_s1", int'(width2), 255);
    idle(1);
    chk("t2_w1_s2", int'(width1), 50);
    idle(1);
    chk("t2_w1_s3", int'(width1), 0);
    chk("t2_w2_s3", int'(width2), 255);
    chk("t2_done", int'(done), 1);
    idle(1);

    // 4: abort beats start mid-ramp
    do_reset();
    tick(1, 0, 0, 10, 4, 3, 2);
    idle(4);
    tick(1, 1, 0, 0, 0, 1, 1);
    chk("t4_busy", int'(busy), 0);
    chk("t4_w1", int'(width1), 6);
    idle(4);
    chk("t4_w1_frozen", int'(width1), 6);
    chk("t4_done", int'(done), 0);

    // 5: retarget from (6,4)
    do_reset();
    tick(1, 0, 0, 10, 4, 3, 2);
    idle(4);
    tick(1, 0, 0, 0, 8, 2, 1);
    idle(1);
    chk("t5_w1_a", int'(width1), 4);
    chk("t5_w2_a", int'(width2), 6);
    idle(2);
    chk("t5_w1_c", int'(width1), 0);
    chk("t5_w2_c", int'(width2), 8);
    chk("t5_done", int'(done), 1);
    idle(1);

    // 6: degenerate configs
    do_reset();
    tick(1, 0, 0, 0, 0, 5, 5);
    chk("t6_done_eq", int'(done), 1);
    chk("t6_busy_eq", int'(busy), 0);
    tick(1, 0, 0, 2, 0, 0, 0);
    idle(1);
    chk("t6_w1_a", int'(width1), 1);
    idle(1);
    chk("t6_w1_b", int'(width1), 2);
    chk("t6_done", int'(done), 1);

    // Randomized traffic against the model, with occasional mid-ramp resets
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      else tick($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 2,
                $urandom_range(0, 99) < 20,
                int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 60)), int'($urandom_range(0, 4)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pwm_ramp_sequencer.md
Name: pwm_ramp_sequencer

Overview:
Hardware fade sequencer for the dual-channel PWM peripheral. It drives the two 8-bit pulse-width inputs of pwm_x2 and ramps them from their current values toward CPU-supplied targets in fixed steps at a programmable tick rate. This offloads per-step width updates from the picorv32. Configuration comes from memory-mapped control registers in system_picorv32; width1/width2 replace the direct width-register connections to pwm_x2.

Parameters:
WIDTH, 8, bit width of pulse-width values, targets and step size
PERIOD_W, 32, bit width of the step-period counter

Ports:
sys_clk  input  1  system clock; all state updates on rising edge
sys_reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse; latch config and begin/retarget ramp
abort  input  1  single-cycle pulse; stop ramp, freeze widths
pause  input  1  level; while high in RUN/PAUSED, step timer frozen
target1  input  WIDTH  channel-1 target width
target2  input  WIDTH  channel-2 target width
step_size  input  WIDTH  width increment/decrement per step
step_period  input  PERIOD_W  sys_clk cycles between steps
width1  output  WIDTH  current channel-1 width, to pwm_x2 pwm_pulse_width_1
width2  output  WIDTH  current channel-2 width, to pwm_x2 pwm_pulse_width_2
busy  output  1  high while a ramp is in progress (RUN or PAUSED)
done  output  1  one-cycle pulse when both widths reach targets

Behaviour:
- Reset (async, sys_reset=1): state=IDLE, width1=width2=0, busy=0, done=0, tick counter=0, latched config=0. All outputs are registered.
- Latched config: tgt1, tgt2, step and per are captured on an accepted start.
  - step_size=0 is latched as 1.
  - step_period=0 is latched as 1.
- States: IDLE, RUN, PAUSED.
- Input priority in any state: abort > start > pause.
- IDLE:
  - On start, latch config.
    - If width1==target1 and width2==target2: stay IDLE, busy=0, done=1 on the next cycle only.
    - Otherwise go to RUN, busy=1 from the next cycle, counter=per-1.
  - abort and pause are ignored.
- RUN:
  - If pause=1, go to PAUSED; the counter holds its value.
  - Else if counter!=0, decrement the counter.
  - Else (counter==0), perform a step on both channels in the same edge and reload counter=per-1.
- Step arithmetic, per channel, in WIDTH+1 bits with no wrap-around:
  - If w<tgt: w = min(w+step, tgt).
  - If w>tgt: w = max(w-step, tgt), computed as (w-tgt<=step) ? tgt : w-step.
  - If w==tgt: unchanged.
- Completion: if both channels equal their targets after a step, go to IDLE on that same edge, busy=0, done=1 for exactly one cycle.
- Latency: with start sampled at edge k and no pause, steps occur at edges k+per, k+2*per, and so on.
- PAUSED: when pause=0, return to RUN and resume counting from the held counter value. Widths are held while paused.
- start in RUN/PAUSED (retarget): latch new config, counter=per-1, state=RUN (even if pause=1; pause takes effect on the next cycle). No done pulse is issued. Widths continue from their current values. If the new targets already equal the widths: go to IDLE, busy=0, done pulse.
- abort in RUN/PAUSED: go to IDLE, busy=0, no done pulse, widths frozen at their current values, counter=0.
- abort and start in the same cycle: abort wins and start is dropped.
- done never coincides with busy=1 in the same cycle. done is 0 in every cycle other than the completion pulse.
- Reset asserted mid-ramp: immediate return to the reset values, including widths=0.

Test Plan:
1. Up-ramp. After reset, start with target1=10, target2=4, step=3, period=2 at edge k.
   - Required widths: (3,3)@k+2, (6,4)@k+4, (9,4)@k+6, (10,4)@k+8.
   - busy high k+1..k+8. done=1 only in the cycle after edge k+8.
2. Saturation, no wrap. From widths (250,250), start target1=0, target2=255, step=100, period=1.
   - Required widths: (150,255), then (50,255), then (0,255).
   - done after the 3rd step. Widths never exceed 255 and never wrap below 0.
3. Pause. During test 1, hold pause high for 5 cycles right after the first step.
   - Widths hold at (3,3) and busy stays 1.
   - Each later step is delayed by exactly 5 cycles. Final value is (10,4).
4. Abort priority. Mid-ramp at widths (6,4), assert abort and start together.
   - State goes to IDLE and widths stay (6,4). busy=0, done never pulses, new config is ignored.
5. Retarget. In RUN at widths (6,4), start with target1=0, target2=8, step=2, period=1.
   - Required widths: (4,6), then (2,8), then (0,8). One done pulse only, at the end.
6. Degenerate config. With widths (0,0), start target1=0, target2=0: busy stays 0 and done pulses the next cycle. Then start target1=2, target2=0 with step=0, period=0:
   - Treated as step=1, period=1.
   - Required widths: (1,0) then (2,0) on consecutive edges, then done.
